alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit ALU between two requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and command inputs from registers. It waits a fixed settle time for the ALU's slow combinational outputs, then captures the result and flags. It returns them, tagged with the requester ID, over a valid/ready response channel. It sits between the instruction-issue logic and the ALU; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one slow combinational ALU between two requesters.
//   clock/reset_n          : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready    : per-requester request handshake (req_ready is combinational)
//   req{0,1}_operandA/B/command : request payloads
//   resp_*                 : registered response (id, result, flags, illegal-command error)
//   alu_*                  : registered ALU operands/command out, raw ALU result/flags in
//   busy                   : high whenever the sequencer is not idle
module alu_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_operandA,
  input  logic [WIDTH-1:0] req0_operandB,
  input  logic [3:0]       req0_command,
  input  logic [WIDTH-1:0] req1_operandA,
  input  logic [WIDTH-1:0] req1_operandB,
  input  logic [3:0]       req1_command,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carryout,
  output logic             resp_zero,
  output logic             resp_overflow,
  output logic             resp_error,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [3:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t r_state, w_next;
  logic r_last;
  logic [7:0] r_cnt;
  logic [1:0] w_gnt;
  logic w_acc, w_sel, w_illegal;
  logic [WIDTH-1:0] w_a, w_b;
  logic [3:0] w_cmd;
  // On a tie the requester that did not win last time is granted.
  assign w_gnt     = (r_state != IDLE) ? 2'b00 :
                     (req_valid == 2'b11) ? (r_last ? 2'b01 : 2'b10) : req_valid;
  assign req_ready = w_gnt;
  assign w_acc     = |w_gnt;
  assign w_sel     = w_gnt[1];
  assign w_a       = w_sel ? req1_operandA : req0_operandA;
  assign w_b       = w_sel ? req1_operandB : req0_operandB;
  assign w_cmd     = w_sel ? req1_command : req0_command;
  assign w_illegal = w_cmd > 4'd8;
  assign busy       = r_state != IDLE;
  assign resp_valid = r_state == RESP;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_acc ? (w_illegal ? RESP : BUSY) : IDLE;
      BUSY:    w_next = (r_cnt == 8'd1) ? RESP : BUSY;
      RESP:    w_next = resp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_last        <= 1'b1;
      r_cnt         <= '0;
      alu_operandA  <= '0;
      alu_operandB  <= '0;
      alu_command   <= '0;
      resp_id       <= 1'b0;
      resp_result   <= '0;
      resp_carryout <= 1'b0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_error    <= 1'b0;
    end else begin
      if (w_acc) begin
        resp_id <= w_sel;
        r_last  <= w_sel;
        r_cnt   <= 8'(SETTLE_CYCLES);
        // Illegal commands never reach the ALU; they answer immediately with an error.
        if (w_illegal) begin
          resp_result   <= '0;
          resp_carryout <= 1'b0;
          resp_zero     <= 1'b0;
          resp_overflow <= 1'b0;
          resp_error    <= 1'b1;
        end else begin
          alu_operandA <= w_a;
          alu_operandB <= w_b;
          alu_command  <= w_cmd;
        end
      end
      if (r_state == BUSY) begin
        r_cnt <= r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          resp_result   <= alu_result;
          resp_carryout <= alu_carryout;
          resp_zero     <= alu_zero;
          resp_overflow <= alu_overflow;
          resp_error    <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (SETTLE_CYCLES=4 and =1 builds).
//   Drives both requesters, models the ALU behaviourally, and checks grants, latency and responses.
module tb_alu_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;
  logic [1:0] req_valid, req_ready;
  logic [31:0] req0_operandA, req0_operandB, req1_operandA, req1_operandB;
  logic [3:0] req0_command, req1_command;
  logic resp_valid, resp_ready, resp_id, resp_carryout, resp_zero, resp_overflow, resp_error, busy;
  logic [31:0] resp_result, alu_operandA, alu_operandB, alu_result;
  logic [3:0] alu_command;
  logic alu_carryout, alu_zero, alu_overflow;
  logic [1:0] s_req_valid, s_req_ready;
  logic [31:0] s_a0, s_b0;
  logic [3:0] s_c0;
  logic s_resp_valid, s_resp_id, s_resp_carryout, s_resp_zero, s_resp_overflow, s_resp_error, s_busy;
  logic [31:0] s_resp_result, s_alu_operandA, s_alu_operandB, s_alu_result;
  logic [3:0] s_alu_command;
  logic s_alu_carryout, s_alu_zero;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int prev, t0;
  logic seen;
  function automatic logic [32:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: alu_f = {1'b0, a} + {1'b0, b};
      4'd1: alu_f = {1'b0, a - b};
      4'd2: alu_f = {1'b0, a ^ b};
      4'd3: alu_f = {32'd0, $signed(a) < $signed(b)};
      4'd4: alu_f = {1'b0, a & b};
      4'd5: alu_f = {1'b0, ~(a & b)};
      4'd6: alu_f = {1'b0, ~(a | b)};
      4'd7: alu_f = {1'b0, a | b};
      4'd8: alu_f = {1'b0, a << b[4:0]};
      default: alu_f = 33'd0;
    endcase
  endfunction
  assign {alu_carryout, alu_result} = alu_f(alu_command, alu_operandA, alu_operandB);
  assign alu_zero = alu_result == 32'd0;
  assign alu_overflow = 1'b0;
  assign {s_alu_carryout, s_alu_result} = alu_f(s_alu_command, s_alu_operandA, s_alu_operandB);
  assign s_alu_zero = s_alu_result == 32'd0;
  alu_arbiter #(.WIDTH(32), .SETTLE_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_operandA(req0_operandA), .req0_operandB(req0_operandB), .req0_command(req0_command),
    .req1_operandA(req1_operandA), .req1_operandB(req1_operandB), .req1_command(req1_command),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_carryout(resp_carryout), .resp_zero(resp_zero), .resp_overflow(resp_overflow),
    .resp_error(resp_error), .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_command(alu_command), .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .busy(busy)
  );
  alu_arbiter #(.WIDTH(32), .SETTLE_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req0_operandA(s_a0), .req0_operandB(s_b0), .req0_command(s_c0),
    .req1_operandA(32'd0), .req1_operandB(32'd0), .req1_command(4'd0),
    .resp_valid(s_resp_valid), .resp_ready(1'b1), .resp_id(s_resp_id), .resp_result(s_resp_result),
    .resp_carryout(s_resp_carryout), .resp_zero(s_resp_zero), .resp_overflow(s_resp_overflow),
    .resp_error(s_resp_error), .alu_operandA(s_alu_operandA), .alu_operandB(s_alu_operandB),
    .alu_command(s_alu_command), .alu_result(s_alu_result), .alu_carryout(s_alu_carryout),
    .alu_zero(s_alu_zero), .alu_overflow(1'b0), .busy(s_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
    cyc++;
  endtask
  // Present v, check the grant, accept, then wait for and check the response (resp_ready assumed 1).
  task automatic run_op(input string tag, input logic [1:0] v, input logic [1:0] v_after,
                        input logic [1:0] exp_gnt, input int exp_lat, input logic exp_id,
                        input logic [31:0] exp_res, input logic exp_c, input logic exp_z,
                        input logic exp_err);
    int ts;
    req_valid = v;
    #1;
    chk({tag, "_gnt"}, 32'(req_ready), 32'(exp_gnt));
    tick;
    ts = cyc;
    last_acc = cyc;
    req_valid = v_after;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!resp_valid && cyc - ts < 30) tick;
    chk({tag, "_lat"}, 32'(cyc - ts), 32'(exp_lat));
    chk({tag, "_id"}, 32'(resp_id), 32'(exp_id));
    chk({tag, "_res"}, resp_result, exp_res);
    chk({tag, "_carry"}, 32'(resp_carryout), 32'(exp_c));
    chk({tag, "_zero"}, 32'(resp_zero), 32'(exp_z));
    chk({tag, "_err"}, 32'(resp_error), 32'(exp_err));
    tick;
    chk({tag, "_done"}, 32'(resp_valid), 32'd0);
  endtask
  initial begin
    reset_n = 1'b0;
    req_valid = 2'b00;
    resp_ready = 1'b1;
    req0_operandA = 32'd0; req0_operandB = 32'd0; req0_command = 4'd0;
    req1_operandA = 32'd0; req1_operandB = 32'd0; req1_command = 4'd0;
    s_req_valid = 2'b00; s_a0 = 32'd0; s_b0 = 32'd0; s_c0 = 4'd0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_cmd", 32'(alu_command), 32'd0);
    reset_n = 1'b1;
    tick;
    req0_operandA = 32'h0000104D; req0_operandB = 32'h0A49100C; req0_command = 4'd0;
    run_op("add", 2'b01, 2'b00, 2'b01, 4, 1'b0, 32'h0A492059, 1'b0, 1'b0, 1'b0);
    chk("add_alu_cmd", 32'(alu_command), 32'd0);
    chk("add_alu_a", alu_operandA, 32'h0000104D);
    req0_operandA = 32'd5; req0_operandB = 32'd3; req0_command = 4'd1;
    req_valid = 2'b01;
    #1;
    tick;
    req_valid = 2'b00;
    tick;
    chk("mid_cmd", 32'(alu_command), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_cmd", 32'(alu_command), 32'd0);
    chk("arst_a", alu_operandA, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rvalid", 32'(resp_valid), 32'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick;
      seen = seen | resp_valid;
    end
    chk("arst_noresp", 32'(seen), 32'd0);
    req0_operandA = 32'h10; req0_operandB = 32'h3; req0_command = 4'd1;
    req1_operandA = 32'hF0; req1_operandB = 32'h0F; req1_command = 4'd7;
    for (int g = 0; g < 4; g++) begin
      prev = last_acc;
      run_op((g % 2) ? "rr1" : "rr0", 2'b11, 2'b11, (g % 2) ? 2'b10 : 2'b01, 4, 1'(g % 2),
             (g % 2) ? 32'hFF : 32'hD, 1'b0, 1'b0, 1'b0);
      if (g > 0) chk("rr_spacing", 32'(last_acc - prev), 32'd6);
    end
    req_valid = 2'b00;
    tick;
    req1_operandA = 32'h77; req1_operandB = 32'h11; req1_command = 4'd12;
    resp_ready = 1'b0;
    req_valid = 2'b10;
    #1;
    chk("ill_gnt", 32'(req_ready), 32'b10);
    tick;
    req_valid = 2'b11;
    chk("ill_rvalid", 32'(resp_valid), 32'd1);
    chk("ill_err", 32'(resp_error), 32'd1);
    chk("ill_res", resp_result, 32'd0);
    chk("ill_zero", 32'(resp_zero), 32'd0);
    chk("ill_id", 32'(resp_id), 32'd1);
    chk("ill_alu_cmd", 32'(alu_command), 32'd7);
    chk("ill_alu_a", alu_operandA, 32'hF0);
    repeat (10) begin
      tick;
      chk("hold_rvalid", 32'(resp_valid), 32'd1);
      chk("hold_err", 32'(resp_error), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 2'b00;
    resp_ready = 1'b1;
    tick;
    chk("hs_rvalid", 32'(resp_valid), 32'd0);
    chk("hs_busy", 32'(busy), 32'd0);
    req0_operandA = 32'hFFFFFFFF; req0_operandB = 32'd1; req0_command = 4'd0;
    run_op("carry", 2'b01, 2'b00, 2'b01, 4, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    s_a0 = 32'hFFFF0000; s_b0 = 32'h0F0F0F0F; s_c0 = 4'd4;
    s_req_valid = 2'b01;
    #1;
    chk("s1_gnt", 32'(s_req_ready), 32'b01);
    tick;
    t0 = cyc;
    s_req_valid = 2'b00;
    while (!s_resp_valid && cyc - t0 < 30) tick;
    chk("s1_lat", 32'(cyc - t0), 32'd1);
    chk("s1_res", s_resp_result, 32'h0F0F0000);
    chk("s1_err", 32'(s_resp_error), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
